// File: rtl/bw_mem_store_queue_pkg.sv
// Shared request format, function/size codes and byte-select helpers for the
// BlackWidow memory path.
package bw_mem_store_queue_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 128;
    localparam int TID_W = 8;

    typedef enum logic [3:0] {
        MR_NOP   = 4'd0,
        MR_LOAD  = 4'd1,
        MR_LOADZ = 4'd2,
        MR_STORE = 4'd3
    } mr_func_t;

    typedef enum logic [2:0] {
        byt   = 3'd0,
        wyde  = 3'd1,
        tetra = 3'd2,
        octa  = 3'd3,
        hexi  = 3'd4
    } mr_size_t;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        mr_func_t         func;
        mr_size_t         sz;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } MemoryRequest;

    // Unaligned byte-select pattern for an access size; unknown codes act as octa.
    function automatic logic [15:0] fnSel(input mr_size_t sz);
        logic [15:0] sel;
        case (sz)
            byt:     sel = 16'h0001;
            wyde:    sel = 16'h0003;
            tetra:   sel = 16'h000F;
            octa:    sel = 16'h00FF;
            hexi:    sel = 16'hFFFF;
            default: sel = 16'h00FF;
        endcase
        return sel;
    endfunction

    function automatic logic [DAT_W-1:0] sel_to_mask(input logic [15:0] sel);
        logic [DAT_W-1:0] m;
        m = '0;
        for (int b = 0; b < 16; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    function automatic logic is_load(input mr_func_t f);
        return (f == MR_LOAD) || (f == MR_LOADZ);
    endfunction

endpackage

// File: rtl/bw_sq_fwd_search.sv
// Store-to-load forwarding search for one port: walks the queue oldest to
// youngest, keeps the youngest covering store and flags younger partial overlaps.
module bw_sq_fwd_search
    import bw_mem_store_queue_pkg::*;
#(
    parameter int QDEP = 8,
    parameter int AWID = 32
) (
    input  logic                      en,
    input  MemoryRequest              req,
    input  logic [$clog2(QDEP)-1:0]   head_idx,
    input  logic [QDEP-1:0]           q_vld,
    input  logic [15:0]               q_sel [QDEP],
    input  logic [ADR_W-1:0]          q_adr [QDEP],
    input  logic [DAT_W-1:0]          q_dat [QDEP],
    output logic                      found,
    output logic                      conflict,
    output MemoryRequest              ldo
);

    localparam int IW = $clog2(QDEP);

    logic [15:0]      ld_sel;
    logic [DAT_W-1:0] ld_mask;
    logic [DAT_W-1:0] shifted;
    logic [DAT_W-1:0] merged;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    win;
    logic [3:0]       ofs;
    logic             hit;
    logic             partial;
    logic             sign;
    logic             ld_en;

    always_comb begin
        ld_sel  = fnSel(req.sz) << req.adr[3:0];
        ld_mask = sel_to_mask(fnSel(req.sz));
        hit     = 1'b0;
        partial = 1'b0;
        win     = '0;
        idx     = '0;
        // A later covering store supersedes any older partial overlap.
        for (int k = 0; k < QDEP; k++) begin
            idx = head_idx + IW'(k);
            if (q_vld[idx] && (q_adr[idx][AWID-1:4] == req.adr[AWID-1:4])) begin
                if ((q_sel[idx] & ld_sel) == ld_sel) begin
                    hit     = 1'b1;
                    win     = idx;
                    partial = 1'b0;
                end else if ((q_sel[idx] & ld_sel) != 16'h0000) begin
                    partial = 1'b1;
                end
            end
        end

        ofs     = req.adr[3:0] - q_adr[win][3:0];
        shifted = q_dat[win] >> {ofs, 3'b000};
        sign    = |(shifted & ld_mask & ~(ld_mask >> 1));
        merged  = (shifted & ld_mask) |
                  (((req.func == MR_LOAD) && sign) ? ~ld_mask : '0);

        ld_en    = en && is_load(req.func);
        found    = ld_en && hit && !partial;
        conflict = ld_en && partial;

        ldo = req;
        if (found) begin
            ldo.dat = merged;
        end
    end

endmodule

// File: rtl/bw_mem_store_queue.sv
// Circular multi-port store queue with tid de-duplication, flush and
// per-port store-to-load forwarding.
module bw_mem_store_queue
    import bw_mem_store_queue_pkg::*;
#(
    parameter int AWID  = 32,
    parameter int QDEP  = 8,
    parameter int NPORT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NPORT-1:0]          wr,
    input  MemoryRequest              i [NPORT],
    output logic [NPORT-1:0]          wr_ack,
    input  logic                      rd,
    output MemoryRequest              o,
    output logic                      valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(QDEP):0]     count,
    output MemoryRequest              ldo [NPORT],
    output logic [NPORT-1:0]          found,
    output logic [NPORT-1:0]          conflict
);

    localparam int IW = $clog2(QDEP);
    localparam int PW = IW + 1;

    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [QDEP-1:0]  vld_reg;
    logic [QDEP-1:0]  vld_next;
    logic [NPORT-1:0] ack_reg;
    logic [NPORT-1:0] ack_next;
    logic [NPORT-1:0] we;
    logic [IW-1:0]    waddr [NPORT];
    logic [PW:0]      free_slots;
    logic [PW:0]      slot;
    logic             dup;
    logic             rd_fire;
    logic [IW-1:0]    head_idx;

    MemoryRequest     q_req [QDEP];
    logic [15:0]      q_sel [QDEP];
    logic [ADR_W-1:0] q_adr [QDEP];
    logic [DAT_W-1:0] q_dat [QDEP];

    assign head_idx = head_reg[IW-1:0];
    assign count    = tail_reg - head_reg;
    assign empty    = (count == '0);
    assign full     = (count == PW'(QDEP));
    assign valid    = vld_reg[head_idx];
    assign o        = q_req[head_idx];
    assign wr_ack   = ack_reg;
    assign rd_fire  = rd && valid;

    generate
        for (genvar gi = 0; gi < QDEP; gi++) begin : g_view
            assign q_adr[gi] = q_req[gi].adr;
            assign q_dat[gi] = q_req[gi].dat;
        end
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_fwd
            bw_sq_fwd_search #(
                .QDEP (QDEP),
                .AWID (AWID)
            ) u_fwd (
                .en       (wr[gi]),
                .req      (i[gi]),
                .head_idx (head_idx),
                .q_vld    (vld_reg),
                .q_sel    (q_sel),
                .q_adr    (q_adr),
                .q_dat    (q_dat),
                .found    (found[gi]),
                .conflict (conflict[gi]),
                .ldo      (ldo[gi])
            );
        end
    endgenerate

    // Port grant: ascending priority, consecutive tail slots, slot freed by rd reusable.
    always_comb begin
        free_slots = (PW+1)'(QDEP) - {1'b0, count} + (PW+1)'(rd_fire);
        slot       = '0;
        we         = '0;
        ack_next   = '0;
        dup        = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            waddr[p] = '0;
        end
        for (int p = 0; p < NPORT; p++) begin
            dup = 1'b0;
            if (!flush && wr[p]) begin
                if (is_load(i[p].func)) begin
                    ack_next[p] = found[p];
                end else begin
                    for (int q = 0; q < QDEP; q++) begin
                        if (vld_reg[q] && (q_req[q].tid == i[p].tid)) begin
                            dup = 1'b1;
                        end
                    end
                    for (int e = 0; e < NPORT; e++) begin
                        if ((e < p) && we[e] && (i[e].tid == i[p].tid)) begin
                            dup = 1'b1;
                        end
                    end
                    if (dup) begin
                        ack_next[p] = 1'b1;
                    end else if (slot < free_slots) begin
                        we[p]       = 1'b1;
                        ack_next[p] = 1'b1;
                        waddr[p]    = tail_reg[IW-1:0] + slot[IW-1:0];
                        slot        = slot + 1'b1;
                    end
                end
            end
        end

        // Pop clears first so a write into the just-freed slot wins.
        vld_next = vld_reg;
        if (rd_fire) begin
            vld_next[head_idx] = 1'b0;
        end
        for (int p = 0; p < NPORT; p++) begin
            if (we[p]) begin
                vld_next[waddr[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            vld_reg  <= '0;
            ack_reg  <= '0;
        end else if (flush) begin
            head_reg <= '0;
            tail_reg <= '0;
            vld_reg  <= '0;
            ack_reg  <= '0;
        end else begin
            if (rd_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            tail_reg <= tail_reg + slot[PW-1:0];
            vld_reg  <= vld_next;
            ack_reg  <= ack_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (we[p]) begin
                q_req[waddr[p]] <= i[p];
                q_sel[waddr[p]] <= fnSel(i[p].sz) << i[p].adr[3:0];
            end
        end
    end

endmodule

// File: tb/tb_bw_mem_store_queue.sv
// Directed bench for the store queue: ack and head-order scoreboards plus
// forwarding, conflict, full, flush and reset checks.
module tb_bw_mem_store_queue;
    import bw_mem_store_queue_pkg::*;

    localparam int QDEP  = 8;
    localparam int NPORT = 2;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             flush = 1'b0;
    logic             rd    = 1'b0;
    logic [NPORT-1:0] wr    = '0;
    MemoryRequest     req [NPORT];
    MemoryRequest     o;
    MemoryRequest     ldo [NPORT];
    logic [NPORT-1:0] wr_ack;
    logic [NPORT-1:0] found;
    logic [NPORT-1:0] conflict;
    logic             valid;
    logic             empty;
    logic             full;
    logic [3:0]       count;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [NPORT-1:0] ack_sb [$];
    logic [7:0]       tid_sb [$];

    always #5 clk = ~clk;

    bw_mem_store_queue #(
        .AWID  (32),
        .QDEP  (QDEP),
        .NPORT (NPORT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr       (wr),
        .i        (req),
        .wr_ack   (wr_ack),
        .rd       (rd),
        .o        (o),
        .valid    (valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .ldo      (ldo),
        .found    (found),
        .conflict (conflict)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected ack is queued with the stimulus and compared after the edge.
    task automatic cyc(input logic [NPORT-1:0] exp_ack, input string tag);
        logic [NPORT-1:0] e;
        ack_sb.push_back(exp_ack);
        @(posedge clk);
        #1;
        e = ack_sb.pop_front();
        check(tag, 128'(wr_ack), 128'(e));
        $display("cycle %s: wr_ack=%b", tag, wr_ack);
    endtask

    function automatic MemoryRequest mk(input mr_func_t f, input mr_size_t s,
                                        input logic [7:0] t, input logic [31:0] a,
                                        input logic [127:0] d);
        MemoryRequest r;
        r.tid  = t;
        r.func = f;
        r.sz   = s;
        r.adr  = a;
        r.dat  = d;
        return r;
    endfunction

    initial begin
        req[0] = mk(MR_NOP, byt, 8'd0, 32'h0, 128'h0);
        req[1] = mk(MR_NOP, byt, 8'd0, 32'h0, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 128'(count), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_full", 128'(full), 128'(0));
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_ack", 128'(wr_ack), 128'(0));
        rst = 1'b1;

        // Two stores in one cycle on both ports
        req[0] = mk(MR_STORE, tetra, 8'd1, 32'h100, 128'hAABBCCDD);
        req[1] = mk(MR_STORE, octa, 8'd2, 32'h208, 128'h0102030405060708);
        wr = 2'b11;
        tid_sb.push_back(8'd1);
        tid_sb.push_back(8'd2);
        cyc(2'b11, "two_port_ack");
        wr = 2'b00;
        #1;
        check("count_2", 128'(count), 128'(2));
        check("head_tid", 128'(o.tid), 128'(tid_sb[0]));

        // Forwarding with sign and zero extension
        req[0] = mk(MR_STORE, octa, 8'd5, 32'h108, 128'h80112233_44556677);
        wr = 2'b01;
        tid_sb.push_back(8'd5);
        cyc(2'b01, "store_octa_ack");
        req[0] = mk(MR_LOAD, tetra, 8'd6, 32'h10C, 128'h0);
        #1;
        check("ld_found", 128'(found), 128'(2'b01));
        check("ld_conflict", 128'(conflict), 128'(2'b00));
        check("ld_sext", ldo[0].dat, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_80112233);
        cyc(2'b01, "load_ack");
        req[0] = mk(MR_LOADZ, tetra, 8'd7, 32'h10C, 128'h0);
        #1;
        check("ldz_found", 128'(found), 128'(2'b01));
        check("ldz_zext", ldo[0].dat, 128'h80112233);
        cyc(2'b01, "loadz_ack");

        // Youngest covering store wins; partial overlap conflicts
        req[0] = mk(MR_STORE, byt, 8'd3, 32'h40, 128'h11);
        req[1] = mk(MR_STORE, byt, 8'd4, 32'h40, 128'h22);
        wr = 2'b11;
        tid_sb.push_back(8'd3);
        tid_sb.push_back(8'd4);
        cyc(2'b11, "byte_stores_ack");
        req[1] = mk(MR_LOADZ, byt, 8'd8, 32'h40, 128'h0);
        wr = 2'b10;
        #1;
        check("young_found", 128'(found), 128'(2'b10));
        check("young_dat", ldo[1].dat, 128'h22);
        cyc(2'b10, "young_ack");
        req[0] = mk(MR_LOAD, wyde, 8'd30, 32'h40, 128'h5A5A);
        wr = 2'b01;
        #1;
        check("wyde_conflict", 128'(conflict), 128'(2'b01));
        check("wyde_found", 128'(found), 128'(2'b00));
        check("wyde_ldo_pass", ldo[0].dat, 128'h5A5A);
        cyc(2'b00, "conflict_no_ack");
        req[0] = mk(MR_LOAD, octa, 8'd31, 32'h500, 128'h77);
        #1;
        check("miss_found", 128'(found), 128'(2'b00));
        check("miss_conflict", 128'(conflict), 128'(2'b00));
        check("miss_ldo_pass", ldo[0].dat, 128'h77);
        cyc(2'b00, "miss_no_ack");

        // Fill to full, hold, then rd with two stores
        req[0] = mk(MR_STORE, octa, 8'd10, 32'h600, 128'hA);
        req[1] = mk(MR_STORE, octa, 8'd11, 32'h610, 128'hB);
        wr = 2'b11;
        tid_sb.push_back(8'd10);
        tid_sb.push_back(8'd11);
        cyc(2'b11, "fill_pair_ack");
        req[0] = mk(MR_STORE, octa, 8'd12, 32'h620, 128'hC);
        wr = 2'b01;
        tid_sb.push_back(8'd12);
        cyc(2'b01, "fill_last_ack");
        check("full_set", 128'(full), 128'(1));
        check("full_count", 128'(count), 128'(QDEP));
        req[0] = mk(MR_STORE, octa, 8'd13, 32'h630, 128'hD);
        cyc(2'b00, "full_hold");
        check("full_hold_count", 128'(count), 128'(QDEP));
        req[1] = mk(MR_STORE, octa, 8'd14, 32'h640, 128'hE);
        wr = 2'b11;
        rd = 1'b1;
        tid_sb.push_back(8'd13);
        #1;
        check("pop_head_tid", 128'(o.tid), 128'(tid_sb.pop_front()));
        cyc(2'b01, "rd_full_port0_only");
        rd = 1'b0;
        wr = 2'b00;
        #1;
        check("rd_full_count", 128'(count), 128'(QDEP));
        check("rd_full_full", 128'(full), 128'(1));

        // Drain in age order across the wrap point
        rd = 1'b1;
        for (int n = 0; n < 2 * QDEP && tid_sb.size() > 0; n++) begin
            check("drain_valid", 128'(valid), 128'(1));
            check("drain_tid", 128'(o.tid), 128'(tid_sb.pop_front()));
            $display("drain: tid=%0d count=%0d", o.tid, count);
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
        check("drain_done", 128'(tid_sb.size()), 128'(0));
        check("drain_empty", 128'(empty), 128'(1));
        check("drain_valid_low", 128'(valid), 128'(0));

        // Held request is enqueued once and acked every cycle
        req[0] = mk(MR_STORE, tetra, 8'd9, 32'h300, 128'h99);
        wr = 2'b01;
        repeat (3) cyc(2'b01, "hold_ack");
        wr = 2'b00;
        #1;
        check("hold_count", 128'(count), 128'(1));
        req[0] = mk(MR_STORE, byt, 8'd20, 32'h700, 128'h1);
        req[1] = mk(MR_STORE, byt, 8'd20, 32'h710, 128'h2);
        wr = 2'b11;
        cyc(2'b11, "same_cycle_dup");
        wr = 2'b00;
        #1;
        check("dup_count", 128'(count), 128'(2));

        // Flush beats writes
        req[0] = mk(MR_STORE, byt, 8'd21, 32'h800, 128'h3);
        req[1] = mk(MR_STORE, byt, 8'd22, 32'h810, 128'h4);
        wr = 2'b11;
        flush = 1'b1;
        cyc(2'b00, "flush_no_ack");
        flush = 1'b0;
        wr = 2'b00;
        #1;
        check("flush_count", 128'(count), 128'(0));
        check("flush_empty", 128'(empty), 128'(1));
        check("flush_valid", 128'(valid), 128'(0));

        // Asynchronous reset drops an in-flight ack
        req[0] = mk(MR_STORE, byt, 8'd23, 32'h900, 128'h5);
        wr = 2'b01;
        cyc(2'b01, "pre_reset_ack");
        wr = 2'b00;
        check("pre_reset_count", 128'(count), 128'(1));
        rst = 1'b0;
        #1;
        check("async_ack", 128'(wr_ack), 128'(0));
        check("async_count", 128'(count), 128'(0));
        check("async_empty", 128'(empty), 128'(1));
        check("async_full", 128'(full), 128'(0));
        check("async_valid", 128'(valid), 128'(0));
        rst = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
